// File: rtl/bram_arb_pkg.sv
// -----------------------------------------------------------------------------
// bram_arb_pkg
// Shared widths, requester-id type, read-tag record and the legal RAM read
// latencies for the two-requester block-RAM port arbiter.
// -----------------------------------------------------------------------------
package bram_arb_pkg;

    localparam int DATA_W = 32;   // RAM data width
    localparam int PAR_W  = 4;    // RAM parity width (one bit per byte)
    localparam int WE_W   = 4;    // per-byte write enables

    // Legal RAM read latencies: output register off / on.
    localparam int RD_LAT_NOREG = 1;
    localparam int RD_LAT_OREG  = 2;

    typedef enum logic {
        REQ_ID0 = 1'b0,
        REQ_ID1 = 1'b1
    } req_id_t;

    // One entry of the read-return tag pipeline.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

    function automatic bit is_legal_read_latency(input int lat);
        return (lat == RD_LAT_NOREG) || (lat == RD_LAT_OREG);
    endfunction

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// bram_rd_tag_pipe
// Shift register of {valid, id} read tags, DEPTH stages, advancing every cycle.
// It runs in lock-step with the RAM read pipeline so the last stage marks the
// cycle in which RAM_DO carries the data for that tag.
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   in_tag      tag entering stage 0 at the next edge
//   first_tag   contents of stage 0 (drives the RAM output-register enable)
//   out_tag     contents of the last stage (read data valid this cycle)
// -----------------------------------------------------------------------------
module bram_rd_tag_pipe
    import bram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t in_tag,
    output rd_tag_t first_tag,
    output rd_tag_t out_tag
);

    rd_tag_t [DEPTH-1:0] stages;

    // NOTE: these are ordinary flops, not a memory array, so they are cleared
    // on reset; that is what discards reads in flight when reset hits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign first_tag = stages[0];
    assign out_tag   = stages[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
// Round-robin arbiter sharing one block-RAM port between two requesters.
// A transfer happens on every edge where reqx and gntx are both high; the
// winning request is registered onto the RAM port the following cycle. Reads
// are tracked by a {valid,id} tag pipeline so rvalidx rises exactly
// READ_LATENCY+1 cycles after the transfer cycle, in issue order.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req0/1, we0/1            request valid, per-byte write enables (0 = read)
//   addr0/1, di0/1, dip0/1   request address, write data, write parity
//   gnt0/1                   combinational grant (transfer at next edge)
//   rvalid0/1                rdata/rdatap belong to that requester this cycle
//   rdata, rdatap            read data/parity (pass-through of ram_do/ram_dop)
//   ram_en, ram_we, ram_addr, ram_di, ram_dip   registered RAM port controls
//   ram_regce                RAM output-register enable (READ_LATENCY = 2)
//   ram_do, ram_dop          RAM read data/parity
//   READ_LATENCY must be 1 or 2 (see bram_arb_pkg::is_legal_read_latency).
// -----------------------------------------------------------------------------
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 15,
    parameter int READ_LATENCY = RD_LAT_NOREG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [WE_W-1:0]       we0,
    input  logic [WE_W-1:0]       we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_W-1:0]     di0,
    input  logic [DATA_W-1:0]     di1,
    input  logic [PAR_W-1:0]      dip0,
    input  logic [PAR_W-1:0]      dip1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_W-1:0]     rdata,
    output logic [PAR_W-1:0]      rdatap,
    output logic                  ram_en,
    output logic [WE_W-1:0]       ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_di,
    output logic [PAR_W-1:0]      ram_dip,
    output logic                  ram_regce,
    input  logic [DATA_W-1:0]     ram_do,
    input  logic [PAR_W-1:0]      ram_dop
);

    req_id_t ptr;       // id of the requester granted last
    req_id_t ram_id;    // id of the access currently on the RAM port
    logic    xfer;
    req_id_t sel;
    rd_tag_t push_tag;
    rd_tag_t first_tag;
    rd_tag_t out_tag;

    // Grant: a lone requester always wins; on a tie the one not granted last
    // wins. Forced low during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            gnt0 = req0 && (!req1 || (ptr == REQ_ID1));
            gnt1 = req1 && (!req0 || (ptr == REQ_ID0));
        end
    end

    assign xfer = gnt0 | gnt1;
    assign sel  = gnt1 ? REQ_ID1 : REQ_ID0;

    // RAM port register: loaded on a transfer, otherwise disabled with the
    // address/data holding their last values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= REQ_ID1;
            ram_id   <= REQ_ID0;
            ram_en   <= 1'b0;
            ram_we   <= '0;
            ram_addr <= '0;
            ram_di   <= '0;
            ram_dip  <= '0;
        end else if (xfer) begin
            ptr      <= sel;
            ram_id   <= sel;
            ram_en   <= 1'b1;
            ram_we   <= gnt1 ? we1   : we0;
            ram_addr <= gnt1 ? addr1 : addr0;
            ram_di   <= gnt1 ? di1   : di0;
            ram_dip  <= gnt1 ? dip1  : dip0;
        end else begin
            ram_en   <= 1'b0;
            ram_we   <= '0;
        end
    end

    // The tag enters the pipeline as the access leaves the RAM port register,
    // so each stage lines up with one RAM read stage: stage 0 is the cycle the
    // RAM's output register must capture, the last stage is data-out.
    assign push_tag.valid = ram_en && (ram_we == '0);
    assign push_tag.id    = ram_id;

    bram_rd_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_tag    (push_tag),
        .first_tag (first_tag),
        .out_tag   (out_tag)
    );

    assign ram_regce = (READ_LATENCY == RD_LAT_OREG) && first_tag.valid;
    assign rvalid0   = out_tag.valid && (out_tag.id == REQ_ID0);
    assign rvalid1   = out_tag.valid && (out_tag.id == REQ_ID1);
    assign rdata     = ram_do;
    assign rdatap    = ram_dop;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
// Drives two arbiters (READ_LATENCY 1 and 2) with identical stimulus. Grants
// come from a vector table; RAM-port contents, rvalid and regce come from a
// scoreboard filled at each transfer. Ends with a reset-during-read sequence.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

    localparam int AW = 15;

    typedef struct {
        bit          r0, r1;
        logic [3:0]  we0, we1;
        logic [14:0] a0, a1;
        logic [31:0] d0, d1;
        logic [3:0]  p0, p1;
        bit          g0, g1;
    } vec_t;

    typedef struct {
        int due;
        bit id;
    } tag_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 0, req1 = 0;
    logic [3:0]  we0 = 0, we1 = 0;
    logic [14:0] addr0 = 0, addr1 = 0;
    logic [31:0] di0 = 0, di1 = 0;
    logic [3:0]  dip0 = 0, dip1 = 0;
    logic [31:0] ram_do = 0;
    logic [3:0]  ram_dop = 0;

    logic        g0_a, g1_a, rv0_a, rv1_a, en_a, regce_a;
    logic [31:0] rd_a, di_a;
    logic [3:0]  rdp_a, we_a, dip_a;
    logic [14:0] addr_a;
    logic        g0_b, g1_b, rv0_b, rv1_b, en_b, regce_b;
    logic [31:0] rd_b, di_b;
    logic [3:0]  rdp_b, we_b, dip_b;
    logic [14:0] addr_b;

    always #5 clk = ~clk;

    bram_port_arbiter #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .di0(di0), .di1(di1), .dip0(dip0), .dip1(dip1),
        .gnt0(g0_a), .gnt1(g1_a), .rvalid0(rv0_a), .rvalid1(rv1_a),
        .rdata(rd_a), .rdatap(rdp_a), .ram_en(en_a), .ram_we(we_a), .ram_addr(addr_a),
        .ram_di(di_a), .ram_dip(dip_a), .ram_regce(regce_a), .ram_do(ram_do), .ram_dop(ram_dop));

    bram_port_arbiter #(.ADDR_WIDTH(AW), .READ_LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .di0(di0), .di1(di1), .dip0(dip0), .dip1(dip1),
        .gnt0(g0_b), .gnt1(g1_b), .rvalid0(rv0_b), .rvalid1(rv1_b),
        .rdata(rd_b), .rdatap(rdp_b), .ram_en(en_b), .ram_we(we_b), .ram_addr(addr_b),
        .ram_di(di_b), .ram_dip(dip_b), .ram_regce(regce_b), .ram_do(ram_do), .ram_dop(ram_dop));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected RAM-port state and read-return scoreboards.
    logic        e_en = 0;
    logic [3:0]  e_we = 0, e_dip = 0;
    logic [14:0] e_addr = 0;
    logic [31:0] e_di = 0;
    tag_exp_t    sb1[$];
    tag_exp_t    sb2[$];
    int          regce_q[$];
    vec_t        tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit r0, input bit r1, input logic [3:0] w0,
                                input logic [3:0] w1, input logic [14:0] a0,
                                input logic [14:0] a1, input logic [31:0] d1,
                                input bit g0, input bit g1);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.we0 = w0; v.we1 = w1; v.a0 = a0; v.a1 = a1;
        v.d0 = 32'h1111_0000 | 32'(a0); v.d1 = d1; v.p0 = 4'h5; v.p1 = 4'hA;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 4'h0, 4'h0, 15'h0, 15'h0, 32'h0, 0, 0);
    endfunction

    task automatic check_port();
        check("ram_en L1", en_a, e_en);         check("ram_en L2", en_b, e_en);
        check("ram_we L1", we_a, e_we);         check("ram_we L2", we_b, e_we);
        check("ram_addr L1", addr_a, e_addr);   check("ram_addr L2", addr_b, e_addr);
        check("ram_di L1", di_a, e_di);         check("ram_di L2", di_b, e_di);
        check("ram_dip L1", dip_a, e_dip);      check("ram_dip L2", dip_b, e_dip);
    endtask

    task automatic check_returns();
        bit       x0, x1, y0, y1, rc;
        tag_exp_t t;
        x0 = 0; x1 = 0; y0 = 0; y1 = 0; rc = 0;
        if (sb1.size() > 0 && sb1[0].due == cyc) begin
            t = sb1.pop_front();
            if (t.id) x1 = 1; else x0 = 1;
        end
        if (sb2.size() > 0 && sb2[0].due == cyc) begin
            t = sb2.pop_front();
            if (t.id) y1 = 1; else y0 = 1;
        end
        if (regce_q.size() > 0 && regce_q[0] == cyc) begin
            void'(regce_q.pop_front());
            rc = 1;
        end
        check("rvalid0 L1", rv0_a, x0);  check("rvalid1 L1", rv1_a, x1);
        check("rvalid0 L2", rv0_b, y0);  check("rvalid1 L2", rv1_b, y1);
        check("regce L1", regce_a, 1'b0);
        check("regce L2", regce_b, rc);
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic apply(input vec_t v);
        req0 = v.r0; req1 = v.r1; we0 = v.we0; we1 = v.we1;
        addr0 = v.a0; addr1 = v.a1; di0 = v.d0; di1 = v.d1; dip0 = v.p0; dip1 = v.p1;
        ram_do = $urandom; ram_dop = 4'($urandom_range(0, 15));
        #1;
        check("gnt0 L1", g0_a, v.g0);  check("gnt1 L1", g1_a, v.g1);
        check("gnt0 L2", g0_b, v.g0);  check("gnt1 L2", g1_b, v.g1);
        check("rdata", rd_a, ram_do);  check("rdatap", rdp_b, ram_dop);
        if (v.g0 || v.g1) begin
            e_en = 1;
            e_we = v.g1 ? v.we1 : v.we0;  e_addr = v.g1 ? v.a1 : v.a0;
            e_di = v.g1 ? v.d1  : v.d0;   e_dip  = v.g1 ? v.p1 : v.p0;
            if (e_we == 4'h0) begin
                sb1.push_back('{due: cyc + 2, id: v.g1});
                sb2.push_back('{due: cyc + 3, id: v.g1});
                regce_q.push_back(cyc + 2);
            end
        end else begin
            e_en = 0;
            e_we = 4'h0;
        end
        @(posedge clk);
        cyc++;
        #1;
        check_port();
        check_returns();
    endtask

    initial begin
        // Grants expected from an all-clear reset (requester 0 wins first tie).
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 1, 4'h0, 4'h0, 15'(2*i+1), 15'(2*i+2), 32'h0, (i % 2) == 0, (i % 2) == 1));
        for (int i = 0; i < 4; i++) tbl.push_back(idle());
        tbl.push_back(mk(1, 0, 4'h0, 4'h0, 15'h0010, 15'h0, 32'h0, 1, 0));           // single read
        for (int i = 0; i < 3; i++) tbl.push_back(idle());
        tbl.push_back(mk(0, 1, 4'h0, 4'hF, 15'h0, 15'h0020, 32'hDEADBEEF, 0, 1));     // write
        for (int i = 0; i < 3; i++) tbl.push_back(idle());
        tbl.push_back(mk(1, 0, 4'h0, 4'h0, 15'h0030, 15'h0, 32'h0, 1, 0));           // reads 0,1,0
        tbl.push_back(mk(0, 1, 4'h0, 4'h0, 15'h0, 15'h0031, 32'h0, 0, 1));
        tbl.push_back(mk(1, 0, 4'h0, 4'h0, 15'h0032, 15'h0, 32'h0, 1, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(idle());
        tbl.push_back(mk(1, 1, 4'h3, 4'h0, 15'h0040, 15'h0041, 32'h0, 0, 1));        // tie, last=0
        tbl.push_back(mk(1, 1, 4'h3, 4'h0, 15'h0040, 15'h0041, 32'h0, 1, 0));
        tbl.push_back(mk(0, 1, 4'h0, 4'h0, 15'h0, 15'h0040, 32'h0, 0, 1));           // read after write
        tbl.push_back(mk(1, 0, 4'h0, 4'h0, 15'h7FFF, 15'h0, 32'h0, 1, 0));           // top address
        for (int i = 0; i < 4; i++) tbl.push_back(idle());

        // Reset state, with a request pending to show grants are held low.
        req0 = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset gnt0", g0_a, 1'b0);   check("reset gnt1", g1_b, 1'b0);
        check_port();
        check("reset regce", regce_b, 1'b0);
        check("reset rvalid", {rv0_a, rv1_a, rv0_b, rv1_b}, 4'h0);
        rst = 0;

        foreach (tbl[i]) apply(tbl[i]);

        // Reset one cycle after a read transfer: everything clears at once and
        // the read never returns.
        apply(mk(0, 1, 4'h0, 4'h0, 15'h0, 15'h0055, 32'h0, 0, 1));
        req0 = 1; req1 = 1;
        rst = 1;
        #1;
        check("rst gnt0", g0_a, 1'b0);  check("rst gnt1", g1_b, 1'b0);
        check("rst ram_en", {en_a, en_b}, 2'b00);
        check("rst ram_we", {we_a, we_b}, 8'h00);
        check("rst ram_addr", {addr_a, addr_b}, 30'h0);
        check("rst ram_di", {di_a, di_b}, 64'h0);
        check("rst ram_dip", {dip_a, dip_b}, 8'h00);
        check("rst rvalid", {rv0_a, rv1_a, rv0_b, rv1_b}, 4'h0);
        check("rst regce", regce_b, 1'b0);
        sb1.delete(); sb2.delete(); regce_q.delete();
        e_en = 0; e_we = 0; e_addr = 0; e_di = 0; e_dip = 0;
        @(posedge clk);
        cyc++;
        #1;
        rst = 0;
        for (int i = 0; i < 5; i++) apply(idle());
        apply(mk(1, 1, 4'h0, 4'h0, 15'h0066, 15'h0067, 32'h0, 1, 0));   // first tie after reset
        for (int i = 0; i < 4; i++) apply(idle());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 15: width of requester and RAM-port address buses.
REQ-002 Parameter READ_LATENCY, default 1: RAM read latency in cycles; legal values 1 (output register off) and 2 (output register on).
REQ-003 CLK  input  1  single clock, rising-edge active; all state is clocked on it.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 REQ0/REQ1  input  1  requester x has a valid access pending.
REQ-006 WE0/WE1  input  4  per-byte write enables; all-zero means read.
REQ-007 ADDR0/ADDR1  input  ADDR_WIDTH  requester x address.
REQ-008 DI0/DI1  input  32, DIP0/DIP1  input  4  requester x write data and parity.
REQ-009 GNT0/GNT1  output  1  access accepted at the next rising CLK edge.
REQ-010 RVALID0/RVALID1  output  1  RDATA/RDATAP carry read data for requester x this cycle.
REQ-011 RDATA  output  32, RDATAP  output  4  read data and parity returned to the requesters.
REQ-012 RAM_EN  output  1, RAM_WE  output  4, RAM_ADDR  output  ADDR_WIDTH  registered RAM port controls.
REQ-013 RAM_DI  output  32, RAM_DIP  output  4, RAM_REGCE  output  1  registered write data/parity; output-register enable.
REQ-014 RAM_DO  input  32, RAM_DOP  input  4  RAM read data and parity.

Function
REQ-015 GNTx SHALL be combinational from REQ0, REQ1 and the priority pointer; at most one GNT high per cycle; GNTx never high without REQx.
REQ-016 A transfer SHALL occur at each edge where REQx and GNTx are both high; one transfer per cycle, full throughput.
REQ-017 Only one REQ high: that requester SHALL be granted. Both high: the requester not granted last SHALL be granted (round-robin).
REQ-018 The priority pointer SHALL update only on a transfer, to the granted requester's id.
REQ-019 The cycle after a transfer, RAM_EN=1 and RAM_WE/RAM_ADDR/RAM_DI/RAM_DIP SHALL equal the granted requester's values; otherwise RAM_EN=0 and RAM_WE=0, with the other RAM outputs holding.
REQ-020 Each read transfer (WE all-zero) SHALL push {valid, id} into a tag pipeline of depth READ_LATENCY; writes push valid=0.
REQ-021 RVALIDx SHALL be high exactly READ_LATENCY+1 cycles after the transfer cycle, one cycle wide; RDATA/RDATAP = RAM_DO/RAM_DOP pass-through.
REQ-022 READ_LATENCY=2: RAM_REGCE SHALL be high in the cycle a read tag sits in the first pipeline stage; READ_LATENCY=1: RAM_REGCE=0.
REQ-023 Back-to-back reads from alternating requesters SHALL return in issue order with correct ids; no read is dropped or duplicated.
REQ-024 A write followed by a read of the same address SHALL be issued in order; data ordering is the RAM's responsibility.
REQ-025 REQx deasserting without a grant is legal; no state changes.

Reset
REQ-026 On RST: RAM_EN=0, RAM_WE=0, RAM_ADDR=0, RAM_DI=0, RAM_DIP=0, RAM_REGCE=0, RVALID0/1=0, tag pipeline cleared, pointer=1 (requester 0 wins the first tie).
REQ-027 GNT0/GNT1 SHALL be forced to 0 while RST is high.
REQ-028 Reads in flight at reset assertion SHALL be discarded; no RVALID for them after release.

Structure
REQ-029 Package bram_arb_pkg SHALL hold data width 32, parity width 4, WE width 4, the requester-id type, and the legal READ_LATENCY values.
REQ-030 Sub-module bram_rd_tag_pipe SHALL implement the {valid,id} shift register of depth READ_LATENCY.

Verification
REQ-031 Single read: REQ0=1, WE0=0, ADDR0=0x0010, READ_LATENCY=1 -> GNT0=1; next cycle RAM_EN=1, RAM_ADDR=0x0010; RVALID0 two cycles after the transfer cycle.
REQ-032 Contention: REQ0=REQ1=1 for 4 cycles after reset -> grants 0,1,0,1.
REQ-033 Write: REQ1=1, WE1=0xF, DI1=0xDEADBEEF -> RAM_WE=0xF, RAM_DI=0xDEADBEEF for one cycle; no RVALID1.
REQ-034 READ_LATENCY=2, reads 0,1,0 on consecutive cycles -> RAM_REGCE pulses; RVALID0,RVALID1,RVALID0 three cycles after each transfer, in order.
REQ-035 RST asserted one cycle after a read transfer -> all outputs 0 immediately; no RVALID after release.
